// File: rtl/audio_pkg.sv
// audio_pkg: shared state encoding, silence word and gain helpers for the audio feeder
package audio_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SCALE, PUSH} state_t;
  localparam logic [31:0] SILENCE = 32'h8000_8000;
  localparam logic [8:0] VOL_UNITY = 9'd256;
  function automatic logic [8:0] clamp_vol(input logic [8:0] v);
    return (v > VOL_UNITY) ? VOL_UNITY : v;
  endfunction
endpackage

// File: rtl/audio_gain_convert.sv
// audio_gain_convert: signed 16-bit sample times unsigned gain (256 = unity), offset to unsigned PCM
module audio_gain_convert (
  input  logic [15:0] sample,
  input  logic [8:0]  vol,
  output logic [15:0] pcm
);
  logic signed [25:0] prod;
  assign prod = 26'($signed(sample)) * 26'($signed({1'b0, vol}));
  assign pcm = 16'(prod >>> 8) ^ 16'h8000;
endmodule

// File: rtl/audio_sample_feeder.sv
// audio_sample_feeder: fetches stereo PCM from RAM, scales it and hands it to audio_output
module audio_sample_feeder
  import audio_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int GAP_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  input  logic [8:0]            volume,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  input  logic [31:0]           mem_rdata,
  output logic [31:0]           audio_data,
  output logic                  audio_valid_toggle,
  input  logic                  audio_full,
  output logic                  busy,
  output logic                  done
);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] addr, base, len, remaining;
  logic [GW-1:0] gap;
  logic [8:0] vol;
  logic [31:0] rdata, pending;
  logic [15:0] pcm_l, pcm_r;
  logic loop_r, flip, last, launch;
  audio_gain_convert u_gain_l (.sample(rdata[15:0]), .vol(vol), .pcm(pcm_l));
  audio_gain_convert u_gain_r (.sample(rdata[31:16]), .vol(vol), .pcm(pcm_r));
  assign mem_addr = addr;
  assign mem_re = (state == FETCH);
  assign busy = (state != IDLE);
  assign last = (remaining == ADDR_WIDTH'(1));
  assign launch = (state == IDLE) && start && !stop && (length != '0);
  // stop outranks a flip that would otherwise happen in the same cycle
  assign flip = (state == PUSH) && !audio_full && (gap == '0) && !stop;
  always_comb begin
    state_n = state;
    if (stop) state_n = IDLE;
    else
      case (state)
        IDLE:    state_n = launch ? FETCH : IDLE;
        FETCH:   state_n = WAIT;
        WAIT:    state_n = SCALE;
        SCALE:   state_n = PUSH;
        PUSH:    state_n = !flip ? PUSH : (last && !loop_r) ? IDLE : FETCH;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      addr <= '0;
      base <= '0;
      len <= '0;
      remaining <= '0;
      loop_r <= 1'b0;
      vol <= VOL_UNITY;
      rdata <= '0;
      pending <= SILENCE;
      audio_data <= SILENCE;
      audio_valid_toggle <= 1'b0;
      gap <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      gap <= flip ? GW'(GAP_CYCLES - 1) : gap - GW'(gap != '0);
      done <= !stop && (((state == IDLE) && start && (length == '0)) || (flip && last && !loop_r));
      if (launch) begin
        base <= base_addr;
        len <= length;
        loop_r <= loop;
        vol <= clamp_vol(volume);
        addr <= base_addr;
        remaining <= length;
      end
      if (state == WAIT) rdata <= mem_rdata;
      if (state == SCALE) pending <= {pcm_r, pcm_l};
      if (flip) begin
        audio_data <= pending;
        audio_valid_toggle <= ~audio_valid_toggle;
        addr <= (last && loop_r) ? base : addr + ADDR_WIDTH'(1);
        remaining <= (last && loop_r) ? len : remaining - ADDR_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_audio_sample_feeder.sv
// tb_audio_sample_feeder: directed checks of fetch, scaling, handshake, looping, stop and reset
module tb_audio_sample_feeder;
  logic clk = 0, reset = 0, start = 0, stop = 0, loop = 0, audio_full = 0;
  logic [11:0] base_addr = 0, length = 0;
  logic [8:0] volume = 9'd256;
  logic [11:0] mem_addr;
  logic mem_re, audio_valid_toggle, busy, done;
  logic [31:0] mem_rdata, audio_data;
  logic [31:0] ram [0:4095];
  int total = 0, bad = 0;
  int flips = 0, dones = 0, reads = 0, cyc = 0;
  int f0, d0, r0;
  logic prev_t = 0, busy_at_done = 1;
  logic [31:0] dq[$];
  logic [11:0] aq[$];
  int tq[$];

  audio_sample_feeder #(.ADDR_WIDTH(12), .GAP_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
    .base_addr(base_addr), .length(length), .volume(volume),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .audio_data(audio_data), .audio_valid_toggle(audio_valid_toggle),
    .audio_full(audio_full), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_re) mem_rdata <= ram[mem_addr];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (reset && audio_valid_toggle !== prev_t) begin
      flips++;
      dq.push_back(audio_data);
      tq.push_back(cyc);
    end
    prev_t = audio_valid_toggle;
    if (done) begin
      dones++;
      busy_at_done = busy;
    end
    if (mem_re) begin
      reads++;
      aq.push_back(mem_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    f0 = flips; d0 = dones; r0 = reads;
    dq.delete(); aq.delete(); tq.delete();
  endtask

  task automatic pulse_start(input logic [11:0] b, input logic [11:0] n, input logic lp, input logic [8:0] v);
    @(negedge clk);
    base_addr = b; length = n; loop = lp; volume = v; start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk(tag, 32'(busy), 0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
    ram[12'h010] = 32'h0000_0000;
    ram[12'h011] = 32'h7FFF_8000;
    ram[12'h012] = 32'hFFFF_0001;
    ram[12'h020] = 32'h4000_0000;
    ram[12'h030] = 32'h1234_5678;
    ram[12'h031] = 32'h0001_0002;
    repeat (3) @(negedge clk);
    chk("rst_data", audio_data, 32'h8000_8000);
    chk("rst_tgl", 32'(audio_valid_toggle), 0);
    chk("rst_busy_re_done", {29'b0, busy, mem_re, done}, 0);
    chk("rst_addr", 32'(mem_addr), 0);
    reset = 1;

    snap();
    pulse_start(12'h010, 12'd3, 0, 9'd256);
    wait_idle("t1_idle");
    chk("t1_flips", flips - f0, 3);
    chk("t1_d0", dq[0], 32'h8000_8000);
    chk("t1_d1", dq[1], 32'hFFFF_0000);
    chk("t1_d2", dq[2], 32'h7FFF_8001);
    chk("t1_done", dones - d0, 1);
    chk("t1_busy_at_done", 32'(busy_at_done), 0);
    chk("t1_reads", reads - r0, 3);
    chk("t1_addrs", {8'h0, aq[0], aq[2]}, {8'h0, 12'h010, 12'h012});
    chk("t1_spacing", tq[1] - tq[0], 4);

    snap();
    pulse_start(12'h020, 12'd1, 0, 9'd128);
    wait_idle("t2a_idle");
    chk("t2_vol128", dq[0], 32'hA000_8000);
    pulse_start(12'h020, 12'd1, 0, 9'd400);
    wait_idle("t2b_idle");
    chk("t2_vol400", dq[1], 32'hC000_8000);

    snap();
    audio_full = 1;
    pulse_start(12'h030, 12'd2, 0, 9'd256);
    repeat (23) @(negedge clk);
    chk("t3_hold_flips", flips - f0, 0);
    chk("t3_hold_data", audio_data, 32'hC000_8000);
    chk("t3_hold_busy", 32'(busy), 1);
    audio_full = 0;
    @(negedge clk);
    chk("t3_release_flip", flips - f0, 1);
    chk("t3_release_data", audio_data, 32'h9234_D678);
    wait_idle("t3_idle");
    chk("t3_second", dq[1], 32'h8001_8002);
    chk("t3_spacing", tq[1] - tq[0], 4);

    snap();
    pulse_start(12'hFFF, 12'd2, 1, 9'd256);
    repeat (15) @(negedge clk);
    stop = 1;
    @(negedge clk);
    stop = 0;
    chk("t4_stop_busy", 32'(busy), 0);
    repeat (20) @(negedge clk);
    chk("t4_flips", flips - f0, 3);
    chk("t4_addrs", {8'h0, aq[0], aq[1]}, {8'h0, 12'hFFF, 12'h000});
    chk("t4_addrs2", {8'h0, aq[2], aq[3]}, {8'h0, 12'hFFF, 12'h000});
    chk("t4_reads", reads - r0, 4);
    chk("t4_no_done", dones - d0, 0);

    snap();
    pulse_start(12'h020, 12'd0, 0, 9'd256);
    repeat (3) @(negedge clk);
    chk("t5_len0_done", dones - d0, 1);
    chk("t5_len0_noread_noflip", {reads - r0, flips - f0}, 0);
    chk("t5_len0_busy", 32'(busy), 0);
    snap();
    pulse_start(12'h020, 12'd1, 0, 9'd256);
    pulse_start(12'h030, 12'd3, 1, 9'd128);
    wait_idle("t5_busy_idle");
    chk("t5_busy_flips", flips - f0, 1);
    chk("t5_busy_data", dq[0], 32'hC000_8000);
    chk("t5_busy_reads", reads - r0, 1);
    chk("t5_busy_addr", 32'(aq[0]), 32'h020);

    audio_full = 1;
    pulse_start(12'h030, 12'd2, 0, 9'd256);
    repeat (5) @(negedge clk);
    chk("t6_pre_tgl", 32'(audio_valid_toggle), 1);
    #2 reset = 0;
    #1;
    chk("t6_rst_data", audio_data, 32'h8000_8000);
    chk("t6_rst_tgl", 32'(audio_valid_toggle), 0);
    chk("t6_rst_busy_re_done", {29'b0, busy, mem_re, done}, 0);
    chk("t6_rst_addr", 32'(mem_addr), 0);
    @(negedge clk);
    reset = 1;
    audio_full = 0;
    snap();
    repeat (10) @(negedge clk);
    chk("t6_post_busy", 32'(busy), 0);
    chk("t6_post_quiet", {reads - r0, flips - f0}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
